// File: rtl/mem_arbiter.sv
// Shares a single-outstanding memory port between instruction fetch and data
// access. Data requests have fixed priority, and a stalled transaction is aborted after TIMEOUT cycles.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       busy;
  logic       rv;
  logic       to;

  // A completion is only accepted while a transaction is outstanding; rvalid wins over timeout.
  always_comb begin
    busy = (state == BUSY_I) || (state == BUSY_D);
    rv   = busy && mem_rvalid;
    to   = busy && (cnt == TIMEOUT_CNT) && !mem_rvalid;
  end

  // Transaction FSM: sample requests in IDLE, latch fields, issue, wait for completion or timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
      cnt       <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          mem_req <= 1'b0;
          cnt     <= 8'd0;
          if (dm_req) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
          end else if (if_req) begin
            state     <= BUSY_I;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_I, BUSY_D: begin
          mem_req <= 1'b0;
          if (rv || to) begin
            state <= IDLE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          cnt     <= 8'd0;
        end
      endcase
    end
  end

  // Completion steering and stall requests; rdata reads as zero unless real data returns.
  always_comb begin
    if_valid  = (state == BUSY_I) && (rv || to);
    dm_valid  = (state == BUSY_D) && (rv || to);
    if_rdata  = ((state == BUSY_I) && rv) ? mem_rdata : 32'h0;
    dm_rdata  = ((state == BUSY_D) && rv) ? mem_rdata : 32'h0;
    bus_err   = to;
    stall_if  = if_req && !if_valid;
    stall_mem = dm_req && !dm_valid;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter; expectations come from a
// transaction-level model (completion at min(delay, TIMEOUT), error if later).
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_rdata;
  logic        dm_valid;
  logic [31:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge where the request(s) for an IDLE cycle are driven.
  // The memory answers 'delay' cycles after the issue cycle (never if delay > TO).
  // The request may be dropped at cycle drop_at (negative: held).
  task automatic run_txn(input bit is_d, input int delay, input int drop_at);
    int done_at;
    bit err;
    logic [31:0] rd;
    logic [31:0] e_addr, e_wdata;
    logic e_we;
    logic [3:0] e_be;
    done_at = (delay <= TO) ? delay : TO;
    err = (delay > TO);
    e_addr  = is_d ? dm_addr : if_addr;
    e_we    = is_d ? dm_we : 1'b0;
    e_be    = is_d ? dm_be : 4'b0000;
    e_wdata = dm_wdata;
    mem_rvalid = 1'b0;
    #1;
    chk("idle_mem_req", {31'b0, mem_req}, 32'd0);
    chk("idle_stall_if", {31'b0, stall_if}, {31'b0, if_req});
    chk("idle_stall_mem", {31'b0, stall_mem}, {31'b0, dm_req});
    for (int k = 0; k <= done_at; k++) begin
      @(negedge clk);
      if (k == drop_at) begin
        if (is_d) dm_req = 1'b0;
        else if_req = 1'b0;
      end
      mem_rvalid = (k == delay);
      rd = $urandom;
      mem_rdata = rd;
      #1;
      chk("mem_req", {31'b0, mem_req}, {31'b0, (k == 0)});
      if (k == 0) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
        chk("mem_be", {28'b0, mem_be}, {28'b0, e_be});
        if (is_d) chk("mem_wdata", mem_wdata, e_wdata);
      end
      chk("if_valid", {31'b0, if_valid}, {31'b0, (!is_d && k == done_at)});
      chk("dm_valid", {31'b0, dm_valid}, {31'b0, (is_d && k == done_at)});
      chk("if_rdata", if_rdata, (!is_d && k == done_at && !err) ? rd : 32'h0);
      chk("dm_rdata", dm_rdata, (is_d && k == done_at && !err) ? rd : 32'h0);
      chk("bus_err", {31'b0, bus_err}, {31'b0, (k == done_at && err)});
      chk("stall_if", {31'b0, stall_if}, {31'b0, (if_req && !(!is_d && k == done_at))});
      chk("stall_mem", {31'b0, stall_mem}, {31'b0, (dm_req && !(is_d && k == done_at))});
      if (k > 0) chk("fields_hold", mem_addr, e_addr);
    end
  endtask

  // Requester side drops its request the cycle after completion.
  task automatic release_req(input bit is_d);
    @(negedge clk);
    if (is_d) dm_req = 1'b0;
    else if_req = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("quiet_mem_req", {31'b0, mem_req}, 32'd0);
  endtask

  initial begin
    int mode;
    int dly;
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_be = 4'h0;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_we_be", {27'b0, mem_we, mem_be}, 32'd0);
    chk("rst_valids", {30'b0, if_valid, dm_valid}, 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Fetch with rvalid 3 cycles after issue.
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    run_txn(1'b0, 3, -1);
    release_req(1'b0);
    idle_cycle();

    // Simultaneous store and fetch: data first, fetch after one idle cycle.
    @(negedge clk);
    if_addr = 32'h100; if_req = 1'b1;
    dm_addr = 32'h2000; dm_wdata = 32'hDEADBEEF; dm_be = 4'hF; dm_we = 1'b1; dm_req = 1'b1;
    run_txn(1'b1, 2, -1);
    release_req(1'b1);
    run_txn(1'b0, 1, -1);
    release_req(1'b0);
    idle_cycle();

    // Load timeout, then rvalid exactly in the timeout cycle.
    @(negedge clk);
    dm_we = 1'b0; dm_addr = 32'h40; dm_be = 4'h0; dm_req = 1'b1;
    run_txn(1'b1, TO + 3, -1);
    release_req(1'b1);
    idle_cycle();
    @(negedge clk);
    dm_req = 1'b1;
    run_txn(1'b1, TO, -1);
    release_req(1'b1);
    idle_cycle();

    // Spurious rvalid while idle, then a normal fetch shows nothing changed.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_0000 + k;
      #1;
      chk("spur_valids", {30'b0, if_valid, dm_valid}, 32'd0);
      chk("spur_rdata", if_rdata | dm_rdata, 32'h0);
      chk("spur_mem_req", {31'b0, mem_req}, 32'd0);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; if_addr = 32'h204; if_req = 1'b1;
    run_txn(1'b0, 2, -1);
    release_req(1'b0);

    // Request dropped mid-flight still completes.
    @(negedge clk);
    dm_we = 1'b1; dm_addr = 32'h3000; dm_wdata = 32'h1234_5678; dm_be = 4'h3; dm_req = 1'b1;
    run_txn(1'b1, 5, 2);
    idle_cycle();

    // Reset two cycles into a fetch abandons it.
    @(negedge clk);
    if_addr = 32'h300; if_req = 1'b1;
    #1 chk("r_idle_mem_req", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    #1 chk("r_issue_mem_req", {31'b0, mem_req}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1; if_req = 1'b0;
    #1;
    chk("r_mem_req", {31'b0, mem_req}, 32'd0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_if_valid", {31'b0, if_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      mem_rvalid = (k == 1); mem_rdata = 32'hCAFE_F00D;
      #1;
      chk("r_after_valids", {30'b0, if_valid, dm_valid}, 32'd0);
      chk("r_after_rdata", if_rdata, 32'h0);
      chk("r_after_mem_req", {31'b0, mem_req}, 32'd0);
      chk("r_after_bus_err", {31'b0, bus_err}, 32'd0);
    end

    // Randomized traffic: fetch only, data only, or both (data must win).
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(0, 2);
      dly = $urandom_range(1, TO + 3);
      @(negedge clk);
      mem_rvalid = 1'b0;
      if_addr = $urandom & 32'hFFFF_FFFC;
      dm_addr = $urandom; dm_wdata = $urandom; dm_we = 1'($urandom_range(0, 1));
      dm_be = 4'($urandom_range(0, 15));
      if_req = (mode != 1);
      dm_req = (mode != 0);
      if (mode == 0) begin
        run_txn(1'b0, dly, -1);
        release_req(1'b0);
      end else begin
        run_txn(1'b1, dly, -1);
        release_req(1'b1);
        if (mode == 2) begin
          run_txn(1'b0, $urandom_range(1, TO + 2), -1);
          release_req(1'b0);
        end
      end
      idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
